// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: turns a UART byte stream into memory write/read requests.
//   'W' <addr bytes> <data bytes> -> memory write; 'R' <addr bytes> -> memory read,
//   with the read word sent back LSB first over the tx handshake.
// Ports: clk/rst (sync active-high), rx_valid/rx_data (byte strobe in),
//   tx_valid/tx_data/tx_ready (byte out), mem_we/mem_waddr/mem_wdata,
//   mem_re/mem_raddr/mem_rdata, mem_rdy (completion), busy/err/overrun status.
// Optional feature: define UART_CMD_SEQ_ACK_EN to send 'K' (0x4B) after each write.
module uart_cmd_sequencer #(
  parameter int NUM_BYTES_DATA    = 4,
  parameter int NUM_BYTES_ADDRESS = 1,
  parameter int TIMEOUT_CYCLES    = 100000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_data,
  output logic                           tx_valid,
  output logic [7:0]                     tx_data,
  input  logic                           tx_ready,
  output logic                           mem_we,
  output logic [NUM_BYTES_ADDRESS*8-1:0] mem_waddr,
  output logic [NUM_BYTES_DATA*8-1:0]    mem_wdata,
  output logic                           mem_re,
  output logic [NUM_BYTES_ADDRESS*8-1:0] mem_raddr,
  input  logic [NUM_BYTES_DATA*8-1:0]    mem_rdata,
  input  logic                           mem_rdy,
  output logic                           busy,
  output logic                           err,
  output logic                           overrun
);

  localparam int AW      = NUM_BYTES_ADDRESS * 8;
  localparam int DW      = NUM_BYTES_DATA * 8;
  localparam int CNT_MAX = (NUM_BYTES_DATA > NUM_BYTES_ADDRESS) ? NUM_BYTES_DATA : NUM_BYTES_ADDRESS;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0] ADDR_LAST = CW'(NUM_BYTES_ADDRESS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(NUM_BYTES_DATA - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    READ,
    SEND
`ifdef UART_CMD_SEQ_ACK_EN
    , ACK
`endif
  } state_t;

  state_t          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rword_q, rword_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            ovr_q, ovr_d;

  logic            mem_we_c, mem_re_c, tx_valid_c;
  logic [7:0]      tx_byte_c;

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rword_d    = rword_q;
    bcnt_d     = bcnt_q;
    tmo_d      = '0;      // gap counter only runs while collecting fields
    err_d      = 1'b0;
    ovr_d      = 1'b0;
    mem_we_c   = 1'b0;
    mem_re_c   = 1'b0;
    tx_valid_c = 1'b0;
    tx_byte_c  = 8'h00;

    case (state_q)
      IDLE: begin
        bcnt_d = '0;
        if (rx_valid) begin
          if (rx_data == 8'h57) begin
            is_wr_d = 1'b1;
            state_d = ADDR;
          end else if (rx_data == 8'h52) begin
            is_wr_d = 1'b0;
            state_d = ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ADDR, DATA: begin
        // A byte arriving on the last allowed cycle still counts.
        if (rx_valid) begin
          if (state_q == ADDR) begin
            for (int i = 0; i < NUM_BYTES_ADDRESS; i++) begin
              if (bcnt_q == CW'(i)) addr_d[i*8 +: 8] = rx_data;
            end
            if (bcnt_q == ADDR_LAST) begin
              bcnt_d = '0;
              if (is_wr_q) state_d = DATA;
              else         state_d = READ;
            end else begin
              bcnt_d = bcnt_q + CW'(1);
            end
          end else begin
            for (int i = 0; i < NUM_BYTES_DATA; i++) begin
              if (bcnt_q == CW'(i)) wdata_d[i*8 +: 8] = rx_data;
            end
            if (bcnt_q == DATA_LAST) begin
              bcnt_d  = '0;
              state_d = WRITE;
            end else begin
              bcnt_d = bcnt_q + CW'(1);
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
          bcnt_d  = '0;
          addr_d  = '0;
          wdata_d = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      WRITE: begin
        mem_we_c = 1'b1;
        ovr_d    = rx_valid;
        if (mem_rdy) begin
`ifdef UART_CMD_SEQ_ACK_EN
          state_d = ACK;
`else
          state_d = IDLE;
`endif
        end
      end

      READ: begin
        mem_re_c = 1'b1;
        ovr_d    = rx_valid;
        if (mem_rdy) begin
          rword_d = mem_rdata;
          bcnt_d  = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        tx_valid_c = 1'b1;
        ovr_d      = rx_valid;
        // Byte index only moves on acceptance, so tx_data holds during a stall.
        for (int i = 0; i < NUM_BYTES_DATA; i++) begin
          if (bcnt_q == CW'(i)) tx_byte_c = rword_q[i*8 +: 8];
        end
        if (tx_ready) begin
          if (bcnt_q == DATA_LAST) begin
            bcnt_d  = '0;
            state_d = IDLE;
          end else begin
            bcnt_d = bcnt_q + CW'(1);
          end
        end
      end

`ifdef UART_CMD_SEQ_ACK_EN
      ACK: begin
        tx_valid_c = 1'b1;
        tx_byte_c  = 8'h4B;
        ovr_d      = rx_valid;
        if (tx_ready) state_d = IDLE;
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      bcnt_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rword_q <= rword_d;
      bcnt_q  <= bcnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  // Outputs are forced low while rst is high so a reset abandons any
  // pending memory request or transmit in the very cycle it is applied.
  assign mem_we    = mem_we_c & ~rst;
  assign mem_re    = mem_re_c & ~rst;
  assign tx_valid  = tx_valid_c & ~rst;
  assign tx_data   = rst ? 8'h00 : tx_byte_c;
  assign mem_waddr = rst ? '0 : addr_q;
  assign mem_raddr = rst ? '0 : addr_q;
  assign mem_wdata = rst ? '0 : wdata_q;
  assign busy      = (state_q != IDLE) & ~rst;
  assign err       = err_q & ~rst;
  assign overrun   = ovr_q & ~rst;

endmodule

// File: doc/uart_cmd_sequencer.md
UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 SHALL have parameter NUM_BYTES_DATA, default 4, data word width in bytes.
REQ-002 SHALL have parameter NUM_BYTES_ADDRESS, default 1, address width in bytes.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, maximum allowed gap between command bytes, in clk cycles.
REQ-004 SHALL have port clk, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port rx_valid, input, 1, one-cycle strobe marking a received UART byte.
REQ-007 SHALL have port rx_data, input, 8, received byte, valid when rx_valid=1.
REQ-008 SHALL have ports tx_valid (output, 1), tx_data (output, 8) and tx_ready (input, 1), the byte-to-transmit handshake.
REQ-009 SHALL have ports mem_we (output, 1), mem_waddr (output, NUM_BYTES_ADDRESS*8) and mem_wdata (output, NUM_BYTES_DATA*8), the memory write request.
REQ-010 SHALL have ports mem_re (output, 1), mem_raddr (output, NUM_BYTES_ADDRESS*8) and mem_rdata (input, NUM_BYTES_DATA*8), the memory read request.
REQ-011 SHALL have port mem_rdy, input, 1, memory completion for the pending request.
REQ-012 SHALL have ports busy (output, 1, state not IDLE), err (output, 1, one-cycle error pulse) and overrun (output, 1, one-cycle dropped-byte pulse).

Function
REQ-013 SHALL use FSM states IDLE, ADDR, DATA, WRITE, READ, SEND and ACK.
REQ-014 In IDLE, rx byte 0x57 ('W') SHALL set the operation to write and go to ADDR; rx byte 0x52 ('R') SHALL set the operation to read and go to ADDR; any other byte SHALL pulse err and stay in IDLE.
REQ-015 ADDR SHALL collect NUM_BYTES_ADDRESS bytes, least significant byte first, then go to DATA for a write or READ for a read.
REQ-016 DATA SHALL collect NUM_BYTES_DATA bytes, least significant byte first, then go to WRITE.
REQ-017 In ADDR/DATA, an inter-byte gap counter SHALL reset on each rx_valid; on reaching TIMEOUT_CYCLES-1 the FSM SHALL pulse err, discard partial fields and return to IDLE.
REQ-018 WRITE SHALL hold mem_we=1 with stable mem_waddr/mem_wdata until mem_rdy=1 is sampled, then drop mem_we the next cycle and go to ACK (macro on) or IDLE (macro off).
REQ-019 READ SHALL hold mem_re=1 with stable mem_raddr until mem_rdy=1, latch mem_rdata in that same cycle, then go to SEND.
REQ-020 A mem_rdy=1 already present on the first WRITE/READ cycle SHALL complete the request in one cycle.
REQ-021 SEND SHALL emit the latched word as NUM_BYTES_DATA bytes, least significant byte first; each byte SHALL advance only on tx_valid&&tx_ready, and tx_data SHALL stay stable while tx_valid=1&&tx_ready=0.
REQ-022 After the last SEND byte, the FSM SHALL return to IDLE.
REQ-023 rx_valid in WRITE, READ, SEND or ACK SHALL drop the byte and pulse overrun, with no state change.
REQ-024 mem_we and mem_re SHALL never be high in the same cycle.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE and clear all byte counters, the timeout counter and the latched address/data/read word.
REQ-026 During and after reset, the outputs mem_we, mem_re, tx_valid, busy, err and overrun SHALL be 0, and tx_data, mem_waddr, mem_raddr and mem_wdata SHALL be 0.
REQ-027 Reset mid-operation SHALL abandon any pending memory request or transmit immediately, with no completion or ACK byte.

Configuration
REQ-028 Macro UART_CMD_SEQ_ACK_EN defined: after a completed write, ACK SHALL present tx_data=0x4B ('K') with tx_valid=1 until accepted, then go to IDLE.
REQ-029 Macro UART_CMD_SEQ_ACK_EN undefined: the ACK state and its logic SHALL be absent, and a write SHALL produce no tx traffic.

Verification
REQ-030 rx 57,10,44,33,22,11, mem_rdy=1 -> one cycle mem_we=1, mem_waddr=0x10, mem_wdata=0x11223344; with macro, tx byte 0x4B.
REQ-031 rx 52,10, mem_rdy asserted 3 cycles after mem_re, mem_rdata=0xDEADBEEF -> mem_re high 4 cycles, tx bytes EF,BE,AD,DE in order.
REQ-032 Read with tx_ready toggling 0/1 every cycle -> tx_data stable while stalled; exactly 4 bytes sent; return to IDLE.
REQ-033 rx 57,10,44 then silence for TIMEOUT_CYCLES (set to 16) -> err pulses once, return to IDLE, no mem_we; next command works.
REQ-034 rx 0x41 in IDLE -> err pulse; rx byte during SEND -> overrun pulse, byte stream unchanged; rst asserted mid-SEND -> tx_valid=0 the next cycle and IDLE.
